// File: rtl/image_mem_responder.sv
// image_mem_responder: owns the image data RAM and walks it through host
// preload (LOAD), processor access (RUN), output streaming (DUMP) and an
// idle terminal state (DONE). The processor only runs while proc_go is high.
module image_mem_responder #(
    parameter int DEPTH    = 4096,
    parameter int IN_BASE  = 0,
    parameter int IN_LEN   = 1024,
    parameter int OUT_BASE = 2048,
    parameter int OUT_LEN  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] RAM_ADDRESS,
    input  logic        RAM_en,
    input  logic        M_Write,
    input  logic [15:0] DATA_BUS_out,
    output logic [15:0] DATA_BUS_in,
    input  logic        End_of_process,
    output logic        proc_go,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [1:0]  phase
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {P_LOAD = 2'b00, P_RUN = 2'b01, P_DUMP = 2'b10, P_DONE = 2'b11} phase_t;

    phase_t      r_phase, w_phase_nxt;
    logic [15:0] r_mem [DEPTH];
    logic [16:0] r_ld_ptr;
    logic [16:0] r_rd_ptr;
    logic [15:0] r_rd_data;
    logic        r_inflight, r_inf_last;
    logic        r_sk_vld, r_sk_last;
    logic [15:0] r_sk_data;

    logic        w_we;
    logic [15:0] w_waddr, w_wdata;

    function automatic logic in_range(input logic [15:0] a);
        return {16'd0, a} < 32'(DEPTH);
    endfunction

    wire logic        w_ld_acc    = ld_valid & ld_ready;
    wire logic        w_ld_final  = ld_last | (r_ld_ptr == 17'(IN_LEN - 1));
    wire logic [15:0] w_ld_addr   = 16'(IN_BASE) + r_ld_ptr[15:0];
    wire logic        w_pop       = out_valid & out_ready;
    // Words owned by the dump pipe: output reg, skid reg and the read in flight.
    wire logic [1:0]  w_occ       = {1'b0, out_valid} + {1'b0, r_sk_vld} + {1'b0, r_inflight};
    // Only fetch when the word is guaranteed a slot (output or skid) on arrival.
    wire logic        w_issue     = (r_phase == P_DUMP) && (r_rd_ptr < 17'(OUT_LEN)) &&
                                    ((w_occ - {1'b0, w_pop}) <= 2'd1);
    wire logic [15:0] w_dump_addr = 16'(OUT_BASE) + r_rd_ptr[15:0];
    wire logic        w_proc_rd   = (r_phase == P_RUN) && RAM_en && !M_Write;

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_phase <= P_LOAD;
        else        r_phase <= w_phase_nxt;
    end

    // Phase transitions.
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            P_LOAD:  if (w_ld_acc && w_ld_final) w_phase_nxt = P_RUN;
            P_RUN:   if (End_of_process)         w_phase_nxt = P_DUMP;
            P_DUMP:  if (w_pop && out_last)      w_phase_nxt = P_DONE;
            default: w_phase_nxt = P_DONE;
        endcase
    end

    // Phase-decoded handshake outputs.
    always_comb begin
        ld_ready = (r_phase == P_LOAD);
        proc_go  = (r_phase == P_RUN);
        phase    = r_phase;
    end

    // Single RAM write port: host preload in LOAD, processor writes in RUN.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (r_phase == P_LOAD && w_ld_acc) begin
            w_we    = 1'b1;
            w_waddr = w_ld_addr;
            w_wdata = ld_data;
        end else if (r_phase == P_RUN && RAM_en && M_Write) begin
            w_we    = 1'b1;
            w_waddr = RAM_ADDRESS;
            w_wdata = DATA_BUS_out;
        end
    end

    // RAM array (never reset) with the synchronous dump prefetch read.
    always_ff @(posedge clk) begin
        if (w_we && in_range(w_waddr)) r_mem[w_waddr[AW-1:0]] <= w_wdata;
        if (w_issue) r_rd_data <= in_range(w_dump_addr) ? r_mem[w_dump_addr[AW-1:0]] : 16'd0;
    end

    // Processor read data: one-cycle latency, holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         DATA_BUS_in <= '0;
        else if (w_proc_rd) DATA_BUS_in <= in_range(RAM_ADDRESS) ? r_mem[RAM_ADDRESS[AW-1:0]] : 16'd0;
    end

    // Preload pointer advances on every accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_ld_ptr <= '0;
        else if (r_phase == P_LOAD && w_ld_acc)   r_ld_ptr <= r_ld_ptr + 17'd1;
    end

    // Dump pipe: read issue, skid buffer and held output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_inf_last <= 1'b0;
            r_sk_vld   <= 1'b0;
            r_sk_data  <= '0;
            r_sk_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr   <= r_rd_ptr + 17'd1;
                r_inf_last <= (r_rd_ptr == 17'(OUT_LEN - 1));
            end
            if (!out_valid || w_pop) begin
                if (r_sk_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= r_sk_data;
                    out_last  <= r_sk_last;
                    r_sk_vld  <= r_inflight;
                    r_sk_data <= r_rd_data;
                    r_sk_last <= r_inf_last;
                end else if (r_inflight) begin
                    out_valid <= 1'b1;
                    out_data  <= r_rd_data;
                    out_last  <= r_inf_last;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (r_inflight) begin
                r_sk_vld  <= 1'b1;
                r_sk_data <= r_rd_data;
                r_sk_last <= r_inf_last;
            end
        end
    end
endmodule

// File: tb/tb_image_mem_responder.sv
// Directed bench for image_mem_responder: preload, RUN accesses, end-of-process
// write, stalled dump stream, IN_LEN cap, and reset in the middle of a dump.
module tb_image_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] RAM_ADDRESS, DATA_BUS_out;
    logic        RAM_en, M_Write, End_of_process, out_ready;
    logic        ld_valid, ld_last, ldb_valid, ldb_last;
    logic [15:0] ld_data, ldb_data;

    logic [15:0] DATA_BUS_in, out_data, b_dbi, b_out_data;
    logic        proc_go, ld_ready, out_valid, out_last;
    logic        b_go, b_ld_ready, b_out_valid, b_out_last;
    logic [1:0]  phase, b_phase;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    image_mem_responder #(.DEPTH(4096), .IN_BASE(0), .IN_LEN(1024), .OUT_BASE(2048), .OUT_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .RAM_ADDRESS(RAM_ADDRESS), .RAM_en(RAM_en), .M_Write(M_Write),
        .DATA_BUS_out(DATA_BUS_out), .DATA_BUS_in(DATA_BUS_in), .End_of_process(End_of_process),
        .proc_go(proc_go), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .phase(phase));

    image_mem_responder #(.DEPTH(4096), .IN_BASE(0), .IN_LEN(3), .OUT_BASE(2048), .OUT_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .RAM_ADDRESS(RAM_ADDRESS), .RAM_en(RAM_en), .M_Write(M_Write),
        .DATA_BUS_out(DATA_BUS_out), .DATA_BUS_in(b_dbi), .End_of_process(End_of_process),
        .proc_go(b_go), .ld_valid(ldb_valid), .ld_data(ldb_data), .ld_last(ldb_last),
        .ld_ready(b_ld_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(out_ready), .phase(b_phase));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic proc(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d);
        RAM_en = en; M_Write = wr; RAM_ADDRESS = a; DATA_BUS_out = d;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        proc(1'b1, 1'b0, a, 16'h0);
        tick();
        proc(1'b0, 1'b0, 16'h0, 16'h0);
        chk(tag, {16'h0, DATA_BUS_in}, {16'h0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_w [4];
        logic [6:0]  pat;
        int          accb, hs, first;

        exp_w[0] = 16'h1234; exp_w[1] = 16'h2001; exp_w[2] = 16'h2002; exp_w[3] = 16'h2003;
        pat = 7'b1011001;   // out_ready per cycle: 1,0,0,1,1,0,1 then 1

        rst_n = 1'b0;
        proc(1'b0, 1'b0, 16'h0, 16'h0);
        End_of_process = 1'b0; out_ready = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        ldb_valid = 1'b0; ldb_data = '0; ldb_last = 1'b0;
        #3;
        chk("rst_phase", {30'd0, phase}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_proc_go", {31'd0, proc_go}, 32'd0);
        chk("rst_dbi", {16'd0, DATA_BUS_in}, 32'd0);
        chk("rst_out", {15'd0, out_valid, out_last, out_data}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Preload: A gets 4 words ending with ld_last; B has no ld_last and IN_LEN=3.
        accb = 0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = 16'((i + 1) * 16'h0011); ld_last = (i == 3);
            ldb_valid = 1'b1; ldb_data = 16'(16'h00A1 + i); ldb_last = 1'b0;
            proc(1'b0, 1'b0, 16'h0, 16'h0);
            if (i == 1) proc(1'b1, 1'b0, 16'h0000, 16'h0);    // read during LOAD: ignored
            if (i == 3) proc(1'b1, 1'b1, 16'h0002, 16'hDEAD); // write during LOAD: ignored
            if (i == 3) chk("b_4th_not_ready", {31'd0, b_ld_ready}, 32'd0);
            if (ldb_valid && b_ld_ready) accb++;
            tick();
            if (i == 1) chk("load_dbi_zero", {16'd0, DATA_BUS_in}, 32'd0);
        end
        ld_valid = 1'b0; ld_last = 1'b0; ldb_valid = 1'b0;
        proc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("load_to_run_phase", {30'd0, phase}, 32'd1);
        chk("run_proc_go", {31'd0, proc_go}, 32'd1);
        chk("run_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("b_accepts", accb, 32'd3);
        chk("b_phase_run", {30'd0, b_phase}, 32'd1);

        // Preloaded contents.
        rd_chk("ram0", 16'd0, 16'h0011);
        rd_chk("ram1", 16'd1, 16'h0022);
        rd_chk("ram2", 16'd2, 16'h0033);
        rd_chk("ram3", 16'd3, 16'h0044);

        // Write then read-after-write, out-of-range write/read, read-data hold.
        proc(1'b1, 1'b1, 16'd5, 16'hBEEF); tick();
        rd_chk("raw_5", 16'd5, 16'hBEEF);
        proc(1'b1, 1'b1, 16'hFFFF, 16'h5555); tick();
        rd_chk("oor_read", 16'hFFFF, 16'h0000);
        rd_chk("reread_5", 16'd5, 16'hBEEF);
        tick();
        chk("dbi_hold", {16'd0, DATA_BUS_in}, 32'h0000BEEF);

        // Fill the rest of the output region, then end with a write to OUT_BASE.
        for (int i = 1; i < 4; i++) begin
            proc(1'b1, 1'b1, 16'(2048 + i), 16'(16'h2000 + i)); tick();
        end
        proc(1'b1, 1'b1, 16'd2048, 16'h1234);
        End_of_process = 1'b1;
        tick();
        End_of_process = 1'b0;
        proc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("eop_phase_dump", {30'd0, phase}, 32'd2);
        chk("eop_proc_go", {31'd0, proc_go}, 32'd0);

        // Dump under a stalling out_ready pattern.
        hs = 0; first = -1;
        for (int c = 0; c < 40 && hs < 4; c++) begin
            out_ready = (c < 7) ? pat[c] : 1'b1;
            if (out_valid) begin
                if (first < 0) first = c;
                chk("dump_data", {16'd0, out_data}, {16'd0, exp_w[hs]});
                chk("dump_last", {31'd0, out_last}, {31'd0, hs == 3});
                if (out_ready) hs++;
            end
            tick();
        end
        out_ready = 1'b0;
        chk("dump_handshakes", hs, 32'd4);
        chk("dump_first_valid_by_2", {31'd0, first >= 0 && first <= 2}, 32'd1);
        chk("done_phase", {30'd0, phase}, 32'd3);
        chk("done_out_idle", {30'd0, out_valid, out_last}, 32'd0);
        chk("done_go_ready", {30'd0, proc_go, ld_ready}, 32'd0);
        proc(1'b1, 1'b1, 16'd5, 16'h9999);  // ignored in DONE
        End_of_process = 1'b1;
        tick();
        End_of_process = 1'b0;
        proc(1'b0, 1'b0, 16'h0, 16'h0);
        chk("done_stays", {30'd0, phase}, 32'd3);

        // Second pass: reset while the dump is stalled.
        do_reset();
        ld_valid = 1'b1; ld_data = 16'h0077; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("p2_run", {30'd0, phase}, 32'd1);
        End_of_process = 1'b1;
        tick();
        End_of_process = 1'b0;
        tick(); tick(); tick();
        chk("p2_dump_valid", {31'd0, out_valid}, 32'd1);
        chk("p2_dump_word0", {16'd0, out_data}, 32'h00001234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_phase", {30'd0, phase}, 32'd0);
        chk("mid_rst_out", {15'd0, out_valid, out_last, out_data}, 32'd0);
        chk("mid_rst_hs", {30'd0, ld_ready, proc_go}, 32'd2);
        chk("mid_rst_dbi", {16'd0, DATA_BUS_in}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        ld_valid = 1'b1; ld_data = 16'h0077; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        rd_chk("kept_5", 16'd5, 16'hBEEF);
        rd_chk("kept_1", 16'd1, 16'h0022);
        rd_chk("kept_2049", 16'd2049, 16'h2001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/image_mem_responder.md
Name: image_mem_responder

Overview:
- Memory-side responder for the image processor's RAM master port.
- Owns the image data RAM and sequences it through three phases:
  - host preload of the input image over a valid/ready stream;
  - servicing of processor read/write requests while the processor runs;
  - streaming of the processed output region to the host once the processor raises End_of_process.
- Gates processor execution with proc_go.

Parameters:
- DEPTH, 4096: words of data RAM. Valid addresses are 0..DEPTH-1.
- IN_BASE, 0: first RAM address written during preload.
- IN_LEN, 1024: maximum words accepted during preload.
- OUT_BASE, 2048: first RAM address streamed out during dump.
- OUT_LEN, 1024: words streamed out during dump (≥1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RAM_ADDRESS  in  16  processor word address.
- RAM_en  in  1  processor access request, one access per cycle.
- M_Write  in  1  1=write, 0=read; qualified by RAM_en.
- DATA_BUS_out  in  16  processor write data.
- DATA_BUS_in  out  16  read data returned to processor.
- End_of_process  in  1  processor completion flag.
- proc_go  out  1  processor run enable.
- ld_valid  in  1  preload word valid.
- ld_data  in  16  preload word.
- ld_last  in  1  final preload word; qualified by ld_valid.
- ld_ready  out  1  preload word accepted when ld_valid & ld_ready.
- out_valid  out  1  dump word valid.
- out_data  out  16  dump word.
- out_last  out  1  final dump word.
- out_ready  in  1  host accepts dump word.
- phase  out  2  00 LOAD, 01 RUN, 10 DUMP, 11 DONE.

Behaviour:
- Reset (async, any time, including mid-phase):
  - phase=LOAD, ld_ready=1, proc_go=0, DATA_BUS_in=0, out_valid=0, out_data=0, out_last=0.
  - Load and dump pointers are set to 0.
  - RAM contents are NOT cleared.
- Address rule:
  - All computed addresses are 16-bit, mod 2^16.
  - Write to an address ≥ DEPTH: dropped.
  - Read from an address ≥ DEPTH: returns 0.
- LOAD:
  - Each ld_valid&ld_ready cycle writes ld_data to RAM[IN_BASE+ptr], then ptr++.
  - The accepting cycle is the final one if ld_last=1 or ptr==IN_LEN-1. On the next edge: phase=RUN, ld_ready=0.
  - Processor port is ignored (no writes; DATA_BUS_in holds 0). End_of_process is ignored.
- RUN:
  - proc_go=1 from the first RUN cycle. ld_ready=0; ld_valid is ignored.
  - RAM_en&M_Write: RAM[RAM_ADDRESS] <= DATA_BUS_out at that edge.
  - RAM_en&!M_Write: DATA_BUS_in <= RAM[RAM_ADDRESS] at that edge (1-cycle read latency). DATA_BUS_in holds its value when there is no read.
  - A read in the cycle after a write to the same address returns the new data.
  - When End_of_process=1 is sampled, any access presented in that same cycle is still performed. On the next edge: phase=DUMP, proc_go=0.
- DUMP:
  - Streams RAM[OUT_BASE+k] for k=0..OUT_LEN-1, in order.
  - Synchronous RAM read with an internal prefetch. The first out_valid rises no later than 2 cycles after entering DUMP.
  - Once out_valid=1, out_data and out_last stay stable until out_ready=1.
  - Sustained throughput is one word per cycle while out_ready=1. No word is duplicated or skipped under any out_ready pattern.
  - out_last=1 only with word k=OUT_LEN-1.
  - After the last handshake: phase=DONE, out_valid=0, out_last=0 on the next edge.
- DONE:
  - All outputs idle: proc_go=0, ld_ready=0, out_valid=0.
  - Stays in DONE until reset. The processor port is ignored.
- Simultaneous events:
  - ld_last on a word beyond IN_LEN cannot occur, because the IN_LEN cap ends LOAD first.
  - End_of_process together with RAM_en write: the write is committed.

Test Plan:
- Preload 4 words 0x0011,0x0022,0x0033,0x0044 with ld_last on the 4th (IN_BASE=0) -> RAM[0..3] hold the values; phase=RUN and proc_go=1 on the cycle after the 4th accept; ld_ready=0.
- RUN: write 0xBEEF to address 5, read address 5 next cycle -> DATA_BUS_in=0xBEEF one cycle after the read; write to 0xFFFF (≥DEPTH) then read it -> 0x0000.
- End_of_process asserted in the same cycle as a write of 0x1234 to OUT_BASE -> write committed; proc_go=0 next cycle; the first dump word is 0x1234.
- Dump with OUT_LEN=4 and out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 handshakes in address order; out_data held during stalls; out_last only on the 4th; phase=DONE afterward.
- Preload without ld_last and IN_LEN=3 -> exactly 3 words accepted, 4th ld_valid not accepted, RUN entered.
- Assert rst_n=0 mid-DUMP -> outputs immediately at reset values, phase=LOAD; RAM contents preserved, checked by a subsequent RUN read.
